// File: rtl/hack_pkg.sv
// Shared widths, word/select types and lane state encoding for the 8-way word demux.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam int WAYS   = 8;
    localparam int SEL_W  = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/dmux_lane.sv
// One output lane of the demux: a single-word hold buffer with an EMPTY/FULL handshake FSM.
module dmux_lane
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    lane_state_t state_q;
    lane_state_t state_d;

    // The data word survives an ack; only a write or reset replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            dout    <= '0;
        end else begin
            state_q <= state_d;
            if (wr) begin
                dout <= din;
            end
        end
    end

    // A write in the ack cycle keeps the lane FULL (pass-through refill).
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (wr)         state_d = FULL;
            FULL:    if (ack && !wr) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign valid = (state_q == FULL);

endmodule

// File: rtl/dmux8way16_reg.sv
// Registered 8-way 16-bit demux with per-lane hold buffers.
// Define DMUX8_AUTOSEL_EN to target lanes round-robin from an internal pointer instead of sel.
module dmux8way16_reg
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int WAYS  = hack_pkg::WAYS,
    parameter int SEL_W = hack_pkg::SEL_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in,
    input  logic                        in_valid,
    input  logic [SEL_W-1:0]            sel,
    output logic                        in_ready,
    output logic [SEL_W-1:0]            cur_sel,
    output logic [WAYS-1:0][WIDTH-1:0]  out,
    output logic [WAYS-1:0]             out_valid,
    input  logic [WAYS-1:0]             out_ack
);

    logic            accept;
    logic [WAYS-1:0] wr;

`ifdef DMUX8_AUTOSEL_EN
    logic [SEL_W-1:0] ptr;
    logic             unused_sel;

    assign unused_sel = ^sel;

    // Pointer only moves on an accepted word, so a stalled producer keeps its lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            if (ptr == SEL_W'(WAYS - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + SEL_W'(1);
            end
        end
    end

    assign cur_sel = ptr;
`else
    assign cur_sel = sel;
`endif

    assign in_ready = !out_valid[cur_sel] || out_ack[cur_sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        wr = '0;
        if (accept) begin
            wr[cur_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < WAYS; i++) begin : g_lane
        dmux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .din   (in),
            .ack   (out_ack[i]),
            .dout  (out[i]),
            .valid (out_valid[i])
        );
    end

endmodule
